// File: rtl/perf_counter_bank_if.sv
// rtl/perf_counter_bank_if.sv - shadow read bus between a requester and the counter bank
interface perf_counter_bank_if #(
  parameter int CNT_W = 32
) ();
  logic             rd_req_i;
  logic [4:0]       rd_sel_i;
  logic             rd_valid_o;
  logic [CNT_W-1:0] rd_data_o;
  logic             rd_err_o;

  modport master (
    output rd_req_i, rd_sel_i,
    input  rd_valid_o, rd_data_o, rd_err_o
  );

  modport slave (
    input  rd_req_i, rd_sel_i,
    output rd_valid_o, rd_data_o, rd_err_o
  );
endinterface

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - event/cycle performance counters with shadow snapshot and read port
module perf_counter_bank #(
  parameter int N_EVT = 4,
  parameter int CNT_W = 32,
  parameter int SAT   = 0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [N_EVT-1:0]   evt_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic               snap_i,
  perf_counter_bank_if.slave rd,
  output logic [N_EVT:0]     ovf_o,
  output logic               done_o,
  output logic               busy_o
);

  // Slot N_EVT of every counter array is the cycle counter; it counts like an
  // event channel whose strobe is always high.
  localparam int NC = N_EVT + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q    [NC];
  logic [CNT_W-1:0] cnt_inc  [NC];
  logic [CNT_W-1:0] shadow_q [NC];
  logic [NC-1:0]    inc_en;
  logic             counting;
  logic             limit_hit;
  logic [CNT_W-1:0] rd_mux;
  logic             rd_oor;

  // Per-counter increment value (wrap or saturate) and the auto-stop condition
  always_comb begin
    counting = (state_q == RUN) && start_i;
    inc_en   = {1'b1, evt_i} & {NC{counting}};
    for (int i = 0; i < NC; i++) begin
      if (&cnt_q[i]) cnt_inc[i] = (SAT != 0) ? cnt_q[i] : '0;
      else           cnt_inc[i] = cnt_q[i] + CNT_W'(1);
    end
    limit_hit = inc_en[N_EVT] && (limit_i != '0) && (cnt_inc[N_EVT] == limit_i);
  end

  // Next state: clear dominates, DONE is only left through clear or reset
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = RUN;
        RUN:     if (limit_hit) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Live counters and sticky overflow flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
      ovf_o <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
      ovf_o <= '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (inc_en[i]) begin
          cnt_q[i] <= cnt_inc[i];
          if (&cnt_q[i]) ovf_o[i] <= 1'b1;
        end
      end
    end
  end

  // Shadow snapshot takes the pre-update live values, independent of clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NC; i++) shadow_q[i] <= '0;
    end else if (snap_i) begin
      for (int i = 0; i < NC; i++) shadow_q[i] <= cnt_q[i];
    end
  end

  // Shadow select mux; out-of-range selects read as zero
  always_comb begin
    rd_oor = int'(rd.rd_sel_i) > N_EVT;
    rd_mux = '0;
    for (int i = 0; i < NC; i++) begin
      if (rd.rd_sel_i == 5'(i)) rd_mux = shadow_q[i];
    end
  end

  // One-cycle read response; all response fields are zero when idle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd.rd_valid_o <= 1'b0;
      rd.rd_data_o  <= '0;
      rd.rd_err_o   <= 1'b0;
    end else begin
      rd.rd_valid_o <= rd.rd_req_i;
      rd.rd_data_o  <= (rd.rd_req_i && !rd_oor) ? rd_mux : '0;
      rd.rd_err_o   <= rd.rd_req_i && rd_oor;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - self-checking bench for perf_counter_bank, wrapping and saturating builds
module tb_perf_counter_bank;
  localparam int NE   = 4;
  localparam int NC   = NE + 1;
  localparam int W    = 8;
  localparam int MAXV = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          snap = 1'b0;
  logic          rd_req = 1'b0;
  logic [NE-1:0] evt = '0;
  logic [W-1:0]  limit = '0;
  logic [4:0]    sel = '0;

  logic [NE:0]   ovf_w, ovf_s;
  logic          done_w, done_s, busy_w, busy_s;

  perf_counter_bank_if #(.CNT_W(W)) rd_w ();
  perf_counter_bank_if #(.CNT_W(W)) rd_s ();

  assign rd_w.rd_req_i = rd_req;
  assign rd_w.rd_sel_i = sel;
  assign rd_s.rd_req_i = rd_req;
  assign rd_s.rd_sel_i = sel;

  perf_counter_bank #(.N_EVT(NE), .CNT_W(W), .SAT(0)) dut_w (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .clear_i(clear), .evt_i(evt),
    .limit_i(limit), .snap_i(snap), .rd(rd_w), .ovf_o(ovf_w), .done_o(done_w), .busy_o(busy_w)
  );

  perf_counter_bank #(.N_EVT(NE), .CNT_W(W), .SAT(1)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .clear_i(clear), .evt_i(evt),
    .limit_i(limit), .snap_i(snap), .rd(rd_s), .ovf_o(ovf_s), .done_o(done_s), .busy_o(busy_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model, index 0 = wrapping build, 1 = saturating build.
  // Phase: 0 idle, 1 run, 2 done.
  int m_cnt [2][NC];
  int m_sh  [2][NC];
  int m_ovf [2][NC];
  int m_ph  [2];
  int m_rv  [2];
  int m_re  [2];
  int m_rd  [2];

  function automatic void model_reset();
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < NC; i++) begin
        m_cnt[v][i] = 0; m_sh[v][i] = 0; m_ovf[v][i] = 0;
      end
      m_ph[v] = 0; m_rv[v] = 0; m_re[v] = 0; m_rd[v] = 0;
    end
  endfunction

  function automatic void model_step();
    int si;
    si = int'(sel);
    for (int v = 0; v < 2; v++) begin
      m_rv[v] = rd_req ? 1 : 0;
      m_re[v] = (rd_req && si > NE) ? 1 : 0;
      m_rd[v] = (rd_req && si <= NE) ? m_sh[v][si] : 0;
      if (snap) for (int i = 0; i < NC; i++) m_sh[v][i] = m_cnt[v][i];
      if (clear) begin
        for (int i = 0; i < NC; i++) begin m_cnt[v][i] = 0; m_ovf[v][i] = 0; end
        m_ph[v] = 0;
      end else if (m_ph[v] == 0) begin
        if (start) m_ph[v] = 1;
      end else if (m_ph[v] == 1 && start) begin
        for (int i = 0; i < NC; i++) begin
          if (i == NE || evt[i]) begin
            if (m_cnt[v][i] == MAXV) begin
              m_ovf[v][i] = 1;
              m_cnt[v][i] = (v == 1) ? MAXV : 0;
            end else begin
              m_cnt[v][i] = m_cnt[v][i] + 1;
            end
          end
        end
        if (limit != 0 && m_cnt[v][NE] == int'(limit)) m_ph[v] = 2;
      end
    end
  endfunction

  function automatic logic [16:0] model_word(int v);
    logic [16:0] w;
    w = '0;
    w[16] = (m_ph[v] == 1);
    w[15] = (m_ph[v] == 2);
    for (int i = 0; i < NC; i++) w[10+i] = (m_ovf[v][i] != 0);
    w[9] = (m_rv[v] != 0);
    w[8] = (m_re[v] != 0);
    w[7:0] = 8'(m_rd[v]);
    return w;
  endfunction

  function automatic logic [16:0] dut_word(int v);
    if (v == 0) return {busy_w, done_w, ovf_w, rd_w.rd_valid_o, rd_w.rd_err_o, rd_w.rd_data_o};
    return {busy_s, done_s, ovf_s, rd_s.rd_valid_o, rd_s.rd_err_o, rd_s.rd_data_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model_wrap", 32'(dut_word(0)), 32'(model_word(0)));
    check("model_sat", 32'(dut_word(1)), 32'(model_word(1)));
  endtask

  task automatic quiet();
    start = 0; clear = 0; snap = 0; rd_req = 0; evt = '0; sel = '0;
  endtask

  task automatic do_clear();
    quiet(); clear = 1; cycle(); clear = 0;
  endtask

  task automatic read_check(input string name, input int s, input int exp_w, input int exp_s, input int exp_err);
    rd_req = 1; sel = 5'(s); cycle(); rd_req = 0;
    check({name, "_w"}, {rd_w.rd_valid_o, rd_w.rd_err_o, 8'h00, rd_w.rd_data_o}, {1'b1, 1'(exp_err), 8'h00, 8'(exp_w)});
    check({name, "_s"}, {rd_s.rd_valid_o, rd_s.rd_err_o, 8'h00, rd_s.rd_data_o}, {1'b1, 1'(exp_err), 8'h00, 8'(exp_s)});
  endtask

  typedef struct {
    logic       start, clear, snap, req;
    logic [3:0] evt;
    logic [4:0] sel;
    logic       busy, done, rv, re;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int lows;
    //            start clr snap req evt      sel    busy done rv re rd
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    model_reset();
    #12;
    check("reset_wrap", 32'(dut_word(0)), 32'd0);
    check("reset_sat", 32'(dut_word(1)), 32'd0);
    rst_n = 1;

    // Short scripted run with limit 3
    limit = 8'd3;
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].start; clear = tbl[i].clear; snap = tbl[i].snap;
      rd_req = tbl[i].req; evt = tbl[i].evt; sel = tbl[i].sel;
      cycle();
      check($sformatf("vec%0d_w", i), {busy_w, done_w, rd_w.rd_valid_o, rd_w.rd_err_o, rd_w.rd_data_o},
            {tbl[i].busy, tbl[i].done, tbl[i].rv, tbl[i].re, tbl[i].rd});
      check($sformatf("vec%0d_s", i), {busy_s, done_s, rd_s.rd_valid_o, rd_s.rd_err_o, rd_s.rd_data_o},
            {tbl[i].busy, tbl[i].done, tbl[i].rv, tbl[i].re, tbl[i].rd});
    end
    quiet();

    // Limit 64 auto-stop, then back-to-back shadow reads
    do_clear();
    limit = 8'd64; start = 1; cycle();
    for (int k = 0; k < 64; k++) begin
      evt = {2'b00, (k % 4 == 0), 1'b1};
      cycle();
    end
    check("limit64_done", {done_w, done_s, busy_w, busy_s}, 4'b1100);
    quiet(); snap = 1; cycle(); snap = 0;
    rd_req = 1; sel = 5'd0; cycle();
    check("b2b_sel0", {rd_w.rd_valid_o, rd_w.rd_data_o}, {1'b1, 8'd64});
    sel = 5'd1; cycle();
    check("b2b_sel1", {rd_w.rd_valid_o, rd_w.rd_data_o}, {1'b1, 8'd16});
    sel = 5'd4; cycle();
    check("b2b_sel4", {rd_w.rd_valid_o, rd_w.rd_data_o, rd_s.rd_data_o}, {1'b1, 8'd64, 8'd64});
    rd_req = 0; cycle();
    check("idle_resp", {rd_w.rd_valid_o, rd_w.rd_err_o, rd_w.rd_data_o}, 10'd0);

    // 300 events on channel 2: wrap gives 44, saturate gives 255
    do_clear();
    limit = 8'd0; start = 1; cycle();
    evt = 4'b0100;
    repeat (300) cycle();
    quiet(); snap = 1; cycle(); snap = 0;
    read_check("ovf_cnt2", 2, 44, 255, 0);
    check("ovf_flag2", {ovf_w[2], ovf_s[2]}, 2'b11);

    // Pause: start low for 10 of 30 run cycles
    do_clear();
    start = 1; cycle();
    evt = 4'b0001; lows = 0;
    for (int k = 0; k < 30; k++) begin
      start = !(k >= 10 && k < 20);
      cycle();
      if (!busy_w || !busy_s) lows++;
    end
    check("pause_busy_drops", 32'(lows), 32'd0);
    quiet(); snap = 1; cycle(); snap = 0;
    read_check("pause_cnt0", 0, 20, 20, 0);

    // Clear and snap together keep the pre-clear value in the shadow
    do_clear();
    start = 1; cycle();
    evt = 4'b1000;
    repeat (7) cycle();
    evt = 4'b0000; clear = 1; snap = 1; cycle(); clear = 0; snap = 0; start = 0;
    check("clrsnap_idle", {busy_w, done_w, busy_s, done_s}, 4'b0000);
    read_check("clrsnap_sh3", 3, 7, 7, 0);
    snap = 1; cycle(); snap = 0;
    read_check("clrsnap_live3", 3, 0, 0, 0);
    read_check("sel9_err", 9, 0, 0, 1);

    // Asynchronous reset mid-run with a read in flight
    do_clear();
    start = 1; cycle();
    evt = 4'b0001;
    repeat (5) cycle();
    rd_req = 1; sel = 5'd0; cycle();
    #2 rst_n = 0;
    #1;
    check("async_rst_wrap", 32'(dut_word(0)), 32'd0);
    check("async_rst_sat", 32'(dut_word(1)), 32'd0);
    model_reset();
    quiet();
    #1 rst_n = 1;
    lows = 0;
    repeat (3) begin
      cycle();
      if (rd_w.rd_valid_o || rd_s.rd_valid_o) lows++;
    end
    check("no_resp_after_rst", 32'(lows), 32'd0);

    // Randomized traffic against the model
    do_clear();
    for (int n = 0; n < 2400; n++) begin
      if (n % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: limit = 8'd0;
          1: limit = 8'd30;
          2: limit = 8'd100;
          default: limit = 8'd250;
        endcase
      end
      start  = ($urandom_range(0, 7) != 0);
      clear  = ($urandom_range(0, 63) == 0);
      evt    = 4'($urandom);
      snap   = ($urandom_range(0, 7) == 0);
      rd_req = ($urandom_range(0, 1) == 1);
      sel    = 5'($urandom_range(0, 9));
      cycle();
    end
    quiet();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Parameters
REQ-001 The block SHALL take parameter N_EVT, default 4, the number of event channels (1..16).
REQ-002 The block SHALL take parameter CNT_W, default 32, the width of every counter (8..32).
REQ-003 The block SHALL take parameter SAT, default 0: 0 = counters wrap, 1 = counters saturate at all-ones.

Interface
REQ-004 clk_i  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n_i  input  1  asynchronous, active-low reset.
REQ-006 start_i  input  1  count enable; leaves IDLE and gates counting in RUN.
REQ-007 clear_i  input  1  synchronous clear of all counters, flags and state.
REQ-008 evt_i  input  N_EVT  per-channel event strobes, one count per asserted cycle.
REQ-009 limit_i  input  CNT_W  cycle limit for auto-stop; 0 = unlimited.
REQ-010 snap_i  input  1  copies live counters into shadow registers.
REQ-011 rd_req_i  input  1  shadow read request.
REQ-012 rd_sel_i  input  5  shadow select: 0..N_EVT-1 = event channel, N_EVT = cycle counter.
REQ-013 rd_valid_o  output  1  read data valid.
REQ-014 rd_data_o  output  CNT_W  shadow read data.
REQ-015 rd_err_o  output  1  select out of range, same cycle as rd_valid_o.
REQ-016 ovf_o  output  N_EVT+1  sticky overflow flags; bit N_EVT = cycle counter.
REQ-017 done_o  output  1  high while in DONE.
REQ-018 busy_o  output  1  high while in RUN.

Function
REQ-019 The state machine SHALL have states IDLE, RUN and DONE; IDLE->RUN when start_i=1; RUN->DONE on the edge where the cycle counter reaches limit_i (limit_i!=0); DONE is left only by clear_i or reset.
REQ-020 In RUN with start_i=1, the cycle counter SHALL increment by 1 and each event counter SHALL increment by 1 when its evt_i bit is 1, including the final RUN->DONE cycle.
REQ-021 In RUN with start_i=0, all counters SHALL hold and the state SHALL stay RUN (pause).
REQ-022 In IDLE and DONE no counter SHALL change and evt_i SHALL be ignored.
REQ-023 With SAT=0, a counter at all-ones SHALL wrap to 0 on increment and set its ovf_o bit.
REQ-024 With SAT=1, a counter at all-ones SHALL stay at all-ones on increment and set its ovf_o bit.
REQ-025 ovf_o bits SHALL be sticky until clear_i or reset.
REQ-026 snap_i SHALL load every shadow register with its live counter value from before the same edge's update; shadows otherwise hold.
REQ-027 rd_req_i SHALL produce rd_valid_o=1 exactly one cycle later, with rd_data_o = shadow selected by rd_sel_i as sampled with the request; back-to-back requests SHALL give back-to-back responses.
REQ-028 rd_sel_i > N_EVT SHALL return rd_data_o=0 with rd_err_o=1.
REQ-029 rd_valid_o, rd_err_o and rd_data_o SHALL be 0 in any cycle without a response.
REQ-030 clear_i SHALL zero live counters, the cycle counter and ovf_o, and force IDLE; shadows and a pending read response SHALL be unaffected.
REQ-031 With clear_i and snap_i in the same cycle, the snapshot SHALL capture the pre-clear values.
REQ-032 clear_i SHALL override start_i, evt_i and the limit check in the same cycle.
REQ-033 A snap_i and rd_req_i to the same shadow in the same cycle SHALL return the old shadow value.

Reset
REQ-034 Reset SHALL force IDLE and zero all counters, shadows, ovf_o, done_o, busy_o, rd_valid_o, rd_err_o and rd_data_o immediately, regardless of clk_i.
REQ-035 Reset asserted mid-RUN or with a read pending SHALL discard that activity; no response SHALL appear after release.

Verification
REQ-036 limit_i=64, start_i=1, evt_i[0] every cycle, evt_i[1] every 4th cycle -> done_o after 64 RUN cycles; snap then read sel 0/1/4 -> 64, 16, 64.
REQ-037 SAT=0, CNT_W=8, evt_i[2] for 300 cycles, limit 0 -> counter 2 = 44, ovf_o[2]=1; SAT=1 same stimulus -> 255, ovf_o[2]=1.
REQ-038 start_i low for 10 of 30 cycles in RUN with evt_i[0]=1 -> counter 0 = 20, busy_o stays 1.
REQ-039 Counter 3 at 7; clear_i+snap_i same cycle -> shadow 3 = 7, live 3 = 0, IDLE; read sel 9 -> data 0, rd_err_o=1.
REQ-040 rst_n_i pulsed low between edges mid-RUN with a read pending -> all outputs 0 at once, no rd_valid_o after release.
